// File: rtl/tawas_thread_sched.sv
// Round-robin barrel-thread scheduler: 32 hardware threads, fixed-depth issue pipeline.
// Optional idle-cycle counter enabled by defining TAWAS_SCHED_PERF_EN.
module tawas_thread_sched #(
  parameter int PIPE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_set_en,
  input  logic [4:0]  run_set_id,
  input  logic        run_clr_en,
  input  logic [4:0]  run_clr_id,
  input  logic        stall_set_en,
  input  logic [4:0]  stall_set_id,
  input  logic        stall_clr_en,
  input  logic [4:0]  stall_clr_id,
  output logic        thread_load_en,
  output logic [4:0]  thread_load,
  output logic        wb_thread_vld,
  output logic [4:0]  wb_thread,
  output logic [31:0] run_mask,
  output logic        busy,
  output logic [31:0] idle_cnt
);

  localparam int LAST = PIPE_DEPTH - 1;

  logic [31:0]           run_q, run_d;
  logic [31:0]           stall_q, stall_d;
  logic [31:0]           inflight_q, inflight_d;
  logic [PIPE_DEPTH-1:0] stage_vld_q, stage_vld_d;
  logic [4:0]            stage_id_q [PIPE_DEPTH];
  logic [4:0]            stage_id_d [PIPE_DEPTH];
  logic [4:0]            ptr_q, ptr_d;
  logic                  load_en_q, load_en_d;
  logic [4:0]            load_q, load_d;
  logic                  busy_q, busy_d;

  logic [31:0] retiring;
  logic [31:0] eligible;
  logic        win_vld;
  logic [4:0]  win_id;
  logic [4:0]  cand;

  // A retiring thread may reissue on the same edge its inflight bit would clear.
  for (genvar gi = 0; gi < 32; gi++) begin : g_elig
    assign retiring[gi] = stage_vld_q[LAST] && (stage_id_q[LAST] == 5'(gi));
    assign eligible[gi] = run_q[gi] & ~stall_q[gi] & (~inflight_q[gi] | retiring[gi]);
  end

  always_comb begin
    win_vld = 1'b0;
    win_id  = ptr_q;
    cand    = '0;
    for (int i = 1; i <= 32; i++) begin
      cand = ptr_q + 5'(i);
      if (!win_vld && eligible[cand]) begin
        win_vld = 1'b1;
        win_id  = cand;
      end
    end
  end

  always_comb begin
    run_d = run_q;
    if (run_set_en) run_d[run_set_id] = 1'b1;
    if (run_clr_en) run_d[run_clr_id] = 1'b0;

    stall_d = stall_q;
    if (stall_set_en) stall_d[stall_set_id] = 1'b1;
    if (stall_clr_en) stall_d[stall_clr_id] = 1'b0;

    inflight_d = inflight_q;
    if (stage_vld_q[LAST]) inflight_d[stage_id_q[LAST]] = 1'b0;
    if (win_vld)           inflight_d[win_id]           = 1'b1;

    stage_vld_d = {stage_vld_q[PIPE_DEPTH-2:0], win_vld};
    stage_id_d[0] = win_id;
    for (int k = 1; k < PIPE_DEPTH; k++) stage_id_d[k] = stage_id_q[k-1];

    ptr_d     = win_vld ? win_id : ptr_q;
    load_en_d = win_vld;
    load_d    = win_vld ? win_id : load_q;
    busy_d    = |inflight_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q       <= 32'h0000_0001;
      stall_q     <= '0;
      inflight_q  <= '0;
      stage_vld_q <= '0;
      for (int k = 0; k < PIPE_DEPTH; k++) stage_id_q[k] <= '0;
      ptr_q       <= 5'd31;
      load_en_q   <= 1'b0;
      load_q      <= '0;
      busy_q      <= 1'b0;
    end else begin
      run_q       <= run_d;
      stall_q     <= stall_d;
      inflight_q  <= inflight_d;
      stage_vld_q <= stage_vld_d;
      for (int k = 0; k < PIPE_DEPTH; k++) stage_id_q[k] <= stage_id_d[k];
      ptr_q       <= ptr_d;
      load_en_q   <= load_en_d;
      load_q      <= load_d;
      busy_q      <= busy_d;
    end
  end

  assign thread_load_en = load_en_q;
  assign thread_load    = load_q;
  assign wb_thread_vld  = stage_vld_q[LAST];
  assign wb_thread      = stage_id_q[LAST];
  assign run_mask       = run_q;
  assign busy           = busy_q;

`ifdef TAWAS_SCHED_PERF_EN
  logic [31:0] idle_cnt_q, idle_cnt_d;

  // Saturates rather than wrapping so long idle stretches stay visible.
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (!win_vld && (idle_cnt_q != 32'hFFFF_FFFF)) idle_cnt_d = idle_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) idle_cnt_q <= '0;
    else     idle_cnt_q <= idle_cnt_d;
  end

  assign idle_cnt = idle_cnt_q;
`else
  assign idle_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_tawas_thread_sched.sv
// Scoreboard bench for tawas_thread_sched: a per-edge reference model built on
// "a thread may reissue only PIPE_DEPTH edges after its last issue" feeds a queue.
module tb_tawas_thread_sched;

  localparam int P = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run_set_en = 1'b0, run_clr_en = 1'b0, stall_set_en = 1'b0, stall_clr_en = 1'b0;
  logic [4:0]  run_set_id = '0, run_clr_id = '0, stall_set_id = '0, stall_clr_id = '0;
  logic        thread_load_en, wb_thread_vld, busy;
  logic [4:0]  thread_load, wb_thread;
  logic [31:0] run_mask, idle_cnt;

  always #5 clk = ~clk;

  tawas_thread_sched #(.PIPE_DEPTH(P)) dut (
    .clk(clk), .rst(rst),
    .run_set_en(run_set_en), .run_set_id(run_set_id),
    .run_clr_en(run_clr_en), .run_clr_id(run_clr_id),
    .stall_set_en(stall_set_en), .stall_set_id(stall_set_id),
    .stall_clr_en(stall_clr_en), .stall_clr_id(stall_clr_id),
    .thread_load_en(thread_load_en), .thread_load(thread_load),
    .wb_thread_vld(wb_thread_vld), .wb_thread(wb_thread),
    .run_mask(run_mask), .busy(busy), .idle_cnt(idle_cnt)
  );

  typedef struct {
    logic        en;
    logic [4:0]  id;
    logic        wbv;
    logic [4:0]  wbid;
    logic        bsy;
    logic [31:0] run;
    logic [31:0] idle;
    int          edge_no;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state
  logic [31:0] run_m, stall_m, idle_m;
  logic [4:0]  load_m;
  int          last_iss [32];
  int          ptr_m;
  int          edge_n = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp, input int e);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d got=%0h expected=%0h", name, e, got, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic rse, input logic [4:0] rsi,
                            input logic rce, input logic [4:0] rci, input logic sse,
                            input logic [4:0] ssi, input logic sce, input logic [4:0] sci);
    exp_t e;
    int   win;
    int   t;
    e.en = 1'b0;
    if (r) begin
      run_m = 32'h1; stall_m = '0; ptr_m = 31; load_m = '0; idle_m = '0;
      for (int k = 0; k < 32; k++) last_iss[k] = -1000;
    end else begin
      win = -1;
      for (int i = 1; i <= 32; i++) begin
        t = (ptr_m + i) % 32;
        if (win < 0 && run_m[t] && !stall_m[t] && (edge_n - last_iss[t] >= P)) win = t;
      end
      if (rse) run_m[rsi] = 1'b1;
      if (rce) run_m[rci] = 1'b0;
      if (sse) stall_m[ssi] = 1'b1;
      if (sce) stall_m[sci] = 1'b0;
      if (win >= 0) begin
        last_iss[win] = edge_n; ptr_m = win; load_m = 5'(win); e.en = 1'b1;
      end else begin
`ifdef TAWAS_SCHED_PERF_EN
        if (idle_m != 32'hFFFF_FFFF) idle_m = idle_m + 1;
`endif
      end
    end
    e.id = load_m; e.wbv = 1'b0; e.wbid = '0; e.bsy = 1'b0;
    for (int k = 0; k < 32; k++) begin
      if (last_iss[k] == edge_n - P + 1) begin e.wbv = 1'b1; e.wbid = 5'(k); end
      if (edge_n - last_iss[k] < P) e.bsy = 1'b1;
    end
    e.run = run_m; e.idle = idle_m; e.edge_no = edge_n;
    exp_q.push_back(e);
    edge_n++;
  endtask

  task automatic cyc(input logic r, input logic rse, input logic [4:0] rsi,
                     input logic rce, input logic [4:0] rci, input logic sse,
                     input logic [4:0] ssi, input logic sce, input logic [4:0] sci);
    @(negedge clk);
    rst = r;
    run_set_en = rse;   run_set_id = rsi;   run_clr_en = rce;   run_clr_id = rci;
    stall_set_en = sse; stall_set_id = ssi; stall_clr_en = sce; stall_clr_id = sci;
    model_step(r, rse, rsi, rce, rci, sse, ssi, sce, sci);
  endtask

  task automatic quiet(input int n);
    repeat (n) cyc(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
  endtask

  task automatic do_rst(input int n);
    repeat (n) cyc(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
  endtask

  task automatic run_set(input logic [4:0] id);
    cyc(1'b0, 1'b1, id, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
  endtask

  // Monitor: one expected record per edge, compared 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("load_en", 32'(thread_load_en), 32'(e.en), e.edge_no);
        chk("load_id", 32'(thread_load), 32'(e.id), e.edge_no);
        chk("wb_vld", 32'(wb_thread_vld), 32'(e.wbv), e.edge_no);
        if (e.wbv) chk("wb_id", 32'(wb_thread), 32'(e.wbid), e.edge_no);
        chk("busy", 32'(busy), 32'(e.bsy), e.edge_no);
        chk("run_mask", run_mask, e.run, e.edge_no);
        chk("idle_cnt", idle_cnt, e.idle, e.edge_no);
        if (e.en) $display("edge=%0d issue thread=%0d wb_vld=%0d wb=%0d busy=%0d",
                           e.edge_no, thread_load, wb_thread_vld, wb_thread, busy);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout edge=%0d got=running expected=finished", edge_n);
    $fatal(1, "timeout");
  end

  initial begin
    logic       r, rse, rce, sse, sce;
    logic [4:0] rsi, rci, ssi, sci;
    do_rst(2);
    // Default release: thread 0 alone, then ids 1..3 join
    quiet(12);
    do_rst(1);
    run_set(5'd1); run_set(5'd2); run_set(5'd3);
    quiet(16);
    // All threads running, stall thread 5 then release it
    do_rst(1);
    for (int i = 1; i < 32; i++) run_set(5'(i));
    quiet(6);
    cyc(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 5'd0);
    quiet(40);
    cyc(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5);
    quiet(40);
    // Same-id collisions: clear wins for both run and stall
    cyc(1'b0, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd2, 1'b1, 5'd2);
    quiet(8);
    // Only thread 31 running; clear it while in flight
    do_rst(1);
    cyc(1'b0, 1'b1, 5'd31, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    quiet(12);
    cyc(1'b0, 1'b0, 5'd0, 1'b1, 5'd31, 1'b0, 5'd0, 1'b0, 5'd0);
    quiet(8);
    // Reset with several threads in flight
    do_rst(1);
    run_set(5'd1); run_set(5'd2);
    quiet(3);
    do_rst(1);
    quiet(10);
    // Randomized traffic, narrow ids sometimes to provoke collisions
    for (int c = 0; c < 500; c++) begin
      r   = ($urandom_range(0, 149) == 0);
      rse = ($urandom_range(0, 1) == 0);
      rce = ($urandom_range(0, 3) == 0);
      sse = ($urandom_range(0, 3) == 0);
      sce = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 0) begin
        rsi = 5'($urandom_range(0, 3)); rci = 5'($urandom_range(0, 3));
        ssi = 5'($urandom_range(0, 3)); sci = 5'($urandom_range(0, 3));
      end else begin
        rsi = 5'($urandom_range(0, 31)); rci = 5'($urandom_range(0, 31));
        ssi = 5'($urandom_range(0, 31)); sci = 5'($urandom_range(0, 31));
      end
      cyc(r, rse, rsi, rce, rci, sse, ssi, sce, sci);
    end
    quiet(4);
    @(posedge clk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'd0, edge_n);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
